// File: rtl/core_mem_arbiter_pkg.sv
// rtl/core_mem_arbiter_pkg.sv - shared owner-ID type and limits for the core memory arbiter
package core_arb_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_id_e;

    localparam int MAX_OUTSTANDING_LIMIT = 8;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// rtl/core_mem_arbiter_if.sv - shared single-port memory bus (req/gnt/rvalid) with master/slave views
interface core_mem_arbiter_if;

    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/core_mem_arbiter_id_fifo.sv
// rtl/core_mem_arbiter_id_fifo.sv - owner-ID FIFO recording who issued each accepted transaction
module arb_id_fifo
    import core_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  arb_id_e          push_id_i,
    input  logic             pop_i,
    output arb_id_e          head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    arb_id_e          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one memory port between fetch and data masters
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed data > instr priority.
module core_mem_arbiter
    import core_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_req_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    input  logic [31:0]         instr_addr_i,
    output logic [31:0]         instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    input  logic                data_we_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [31:0]         data_wdata_i,
    output logic [31:0]         data_rdata_o,
    output logic                data_err_o,
    core_mem_arbiter_if.master  mem,
    output logic                busy_o,
    output logic                orphan_rsp_o
);

    localparam int ID_W = $clog2(MAX_OUTSTANDING + 1);

    arb_id_e          arb_sel;
    arb_id_e          sel;
    arb_id_e          head;
    arb_id_e          lock_id_q, lock_id_d;
    logic             lock_q, lock_d;
    logic             orphan_q;
    logic             full, empty;
    logic [ID_W-1:0]  count;
    logic             accept;
    logic             rsp_valid;

`ifdef ARB_ROUND_ROBIN_EN
    arb_id_e rr_q;

    always_comb begin
        arb_sel = ARB_INSTR;
        if (instr_req_i && data_req_i) begin
            arb_sel = rr_q;
        end else if (data_req_i) begin
            arb_sel = ARB_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= ARB_INSTR;
        end else if (accept) begin
            rr_q <= (sel == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
        end
    end
`else
    assign arb_sel = data_req_i ? ARB_DATA : ARB_INSTR;
`endif

    // A master that saw req without gnt keeps the port until the grant arrives.
    assign sel    = lock_q ? lock_id_q : arb_sel;
    assign mem.req = (instr_req_i | data_req_i) & ~full & ~rst;
    assign accept = mem.req & mem.gnt;

    assign mem.we    = (sel == ARB_DATA) ? data_we_i    : 1'b0;
    assign mem.be    = (sel == ARB_DATA) ? data_be_i    : 4'hF;
    assign mem.addr  = (sel == ARB_DATA) ? data_addr_i  : instr_addr_i;
    assign mem.wdata = (sel == ARB_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = accept & (sel == ARB_INSTR);
    assign data_gnt_o  = accept & (sel == ARB_DATA);

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (mem.req && !mem.gnt) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end else if (accept) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= ARB_INSTR;
            orphan_q  <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            orphan_q  <= mem.rvalid & empty;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (accept),
        .push_id_i (sel),
        .pop_i     (mem.rvalid),
        .head_o    (head),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count)
    );

    assign rsp_valid      = mem.rvalid & ~empty & ~rst;
    assign instr_rvalid_o = rsp_valid & (head == ARB_INSTR);
    assign data_rvalid_o  = rsp_valid & (head == ARB_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem.rdata : 32'h0;
    assign data_rdata_o   = data_rvalid_o  ? mem.rdata : 32'h0;
    assign instr_err_o    = instr_rvalid_o & mem.err;
    assign data_err_o     = data_rvalid_o  & mem.err;

    assign busy_o       = (count != '0);
    assign orphan_rsp_o = orphan_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - directed self-checking bench for core_mem_arbiter
module tb_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        busy, orphan;

    int tests_run = 0;
    int tests_failed = 0;

    core_mem_arbiter_if mem_if ();

    core_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_addr_i   (instr_addr),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .mem            (mem_if.master),
        .busy_o         (busy),
        .orphan_rsp_o   (orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
        mem_if.gnt = 0; mem_if.rvalid = 0; mem_if.rdata = 0; mem_if.err = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    logic exp_dgnt [4];

    initial begin
        do_reset();

        sample();
        check("rst_instr_gnt", instr_gnt, 0);
        check("rst_data_gnt", data_gnt, 0);
        check("rst_mem_req", mem_if.req, 0);
        check("rst_busy", busy, 0);
        check("rst_orphan", orphan, 0);
        check("rst_rdata", instr_rdata | data_rdata, 0);
        check("rst_rvalid", {instr_rvalid, data_rvalid, instr_err, data_err}, 0);

`ifndef ARB_ROUND_ROBIN_EN
        // fixed priority: data wins, instr follows
        tick();
        instr_req = 1; instr_addr = 32'h100;
        data_req = 1; data_addr = 32'h200; data_we = 1; data_be = 4'h3; data_wdata = 32'hDEAD;
        mem_if.gnt = 1;
        sample();
        check("t1_mem_req", mem_if.req, 1);
        check("t1_data_gnt", data_gnt, 1);
        check("t1_instr_gnt", instr_gnt, 0);
        check("t1_addr_data", mem_if.addr, 32'h200);
        check("t1_we_data", {mem_if.we, mem_if.be}, 5'b1_0011);
        tick();
        data_req = 0;
        sample();
        check("t1_instr_gnt2", instr_gnt, 1);
        check("t1_addr_instr", mem_if.addr, 32'h100);
        check("t1_fetch_cmd", {mem_if.we, mem_if.be}, 5'b0_1111);
        tick();
        instr_req = 0; mem_if.gnt = 0;
        mem_if.rvalid = 1; mem_if.rdata = 32'hAAAA;
        sample();
        check("t1_busy", busy, 1);
        check("t1_rsp_data", {data_rvalid, instr_rvalid}, 2'b10);
        check("t1_rdata_data", data_rdata, 32'hAAAA);
        check("t1_rdata_instr0", instr_rdata, 0);
        tick();
        mem_if.rdata = 32'hBBBB; mem_if.err = 1;
        sample();
        check("t1_rsp_instr", {data_rvalid, instr_rvalid, instr_err}, 3'b011);
        check("t1_rdata_instr", instr_rdata, 32'hBBBB);
        tick();
        mem_if.rvalid = 0; mem_if.err = 0;
        sample();
        check("t1_idle", busy, 0);
`endif

        // both held 4 cycles; responses keep the FIFO from filling
`ifdef ARB_ROUND_ROBIN_EN
        exp_dgnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_dgnt = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        instr_req = 1; instr_addr = 32'h10;
        data_req = 1; data_addr = 32'h20;
        mem_if.gnt = 1;
        for (int i = 0; i < 4; i++) begin
            mem_if.rvalid = (i != 0);
            sample();
            check($sformatf("t2_dgnt%0d", i), data_gnt, exp_dgnt[i]);
            check($sformatf("t2_ignt%0d", i), instr_gnt, !exp_dgnt[i]);
            tick();
        end
        instr_req = 0; data_req = 0; mem_if.gnt = 0; mem_if.rvalid = 1;
        tick();
        mem_if.rvalid = 0;
        sample();
        check("t2_drained", busy, 0);

        // lock holds data command while grant is withheld
        do_reset();
        data_req = 1; data_addr = 32'h300; data_we = 1;
        instr_addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) instr_req = 1;
            sample();
            check($sformatf("t3_addr%0d", i), mem_if.addr, 32'h300);
            check($sformatf("t3_nogrant%0d", i), {data_gnt, instr_gnt}, 2'b00);
            tick();
        end
        mem_if.gnt = 1;
        sample();
        check("t3_data_gnt", {data_gnt, instr_gnt}, 2'b10);
        check("t3_addr_at_gnt", mem_if.addr, 32'h300);
        tick();
        data_req = 0;
        sample();
        check("t3_instr_gnt", {data_gnt, instr_gnt}, 2'b01);
        check("t3_instr_addr", mem_if.addr, 32'h400);

        // in-order response routing
        do_reset();
        instr_req = 1; instr_addr = 32'hA; mem_if.gnt = 1;
        tick();
        instr_req = 0; data_req = 1; data_addr = 32'hB;
        sample();
        check("t4_data_gnt", data_gnt, 1);
        tick();
        data_req = 0; mem_if.gnt = 0;
        mem_if.rvalid = 1; mem_if.rdata = 32'h1111;
        sample();
        check("t4_instr_rdata", instr_rdata, 32'h1111);
        check("t4_rv_a", {instr_rvalid, data_rvalid}, 2'b10);
        tick();
        mem_if.rdata = 32'h2222;
        sample();
        check("t4_data_rdata", data_rdata, 32'h2222);
        check("t4_rv_b", {instr_rvalid, data_rvalid, instr_rdata[0]}, 3'b010);
        tick();
        mem_if.rvalid = 0;

        // full: no push while popping in the same cycle
        do_reset();
        instr_req = 1; instr_addr = 32'h50; mem_if.gnt = 1;
        tick();
        tick();
        mem_if.gnt = 0; mem_if.rvalid = 1; mem_if.rdata = 32'h5;
        sample();
        check("t5_full_req", mem_if.req, 0);
        check("t5_full_gnt", instr_gnt, 0);
        check("t5_pop", instr_rvalid, 1);
        tick();
        mem_if.rvalid = 0;
        sample();
        check("t5_req_after", mem_if.req, 1);
        check("t5_busy", busy, 1);

        // reset mid-transaction turns late responses into orphans
        do_reset();
        instr_req = 1; mem_if.gnt = 1;
        tick();
        instr_req = 0; mem_if.gnt = 0;
        sample();
        check("t6_busy_pre", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        sample();
        check("t6_busy_post", busy, 0);
        mem_if.rvalid = 1; mem_if.rdata = 32'h77;
        sample();
        check("t6_no_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
        tick();
        mem_if.rvalid = 0;
        sample();
        check("t6_orphan", orphan, 1);
        check("t6_busy", busy, 0);
        tick();
        sample();
        check("t6_orphan_pulse", orphan, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
